// File: rtl/router_pkg.sv
// Shared types, port indices and packet field helpers for the round-robin mesh router.
package router_pkg;

  localparam int NUM_PORTS   = 5;
  localparam int MAX_PKT_W   = 128;
  localparam int MAX_COORD_W = 16;

  typedef logic [2:0] port_t;

  localparam port_t PORT_N    = 3'd0;
  localparam port_t PORT_S    = 3'd1;
  localparam port_t PORT_W    = 3'd2;
  localparam port_t PORT_E    = 3'd3;
  localparam port_t PORT_NODE = 3'd4;

  typedef enum logic [1:0] {SCAN, ROUTE, XMIT} state_t;

  // Packets are passed zero-extended to MAX_PKT_W so one helper serves every parameterisation.
  function automatic logic [MAX_COORD_W-1:0] field_at(input logic [MAX_PKT_W-1:0] pkt,
                                                      input int unsigned lsb,
                                                      input int unsigned coord_w);
    logic [MAX_PKT_W-1:0]   shifted;
    logic [MAX_COORD_W-1:0] mask;
    shifted = pkt >> lsb;
    mask    = (MAX_COORD_W'(1) << coord_w) - MAX_COORD_W'(1);
    return shifted[MAX_COORD_W-1:0] & mask;
  endfunction

  function automatic logic [MAX_COORD_W-1:0] get_dest_x(input logic [MAX_PKT_W-1:0] pkt,
                                                        input int unsigned pkt_w,
                                                        input int unsigned coord_w);
    return field_at(pkt, pkt_w - coord_w, coord_w);
  endfunction

  function automatic logic [MAX_COORD_W-1:0] get_dest_y(input logic [MAX_PKT_W-1:0] pkt,
                                                        input int unsigned pkt_w,
                                                        input int unsigned coord_w);
    return field_at(pkt, pkt_w - 2 * coord_w, coord_w);
  endfunction

endpackage

// File: rtl/rr_arbiter5.sv
// Five-way round-robin arbiter: first requester at or after ptr wins; purely combinational.
import router_pkg::*;

module rr_arbiter5 (
  input  logic [NUM_PORTS-1:0] req,
  input  port_t                ptr,
  output logic [NUM_PORTS-1:0] grant,
  output port_t                grant_idx
);

  logic       found;
  logic [3:0] sum;
  logic [2:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = PORT_N;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      sum = {1'b0, ptr} + 4'(k);
      if (sum >= 4'd5) sum = sum - 4'd5;
      idx = sum[2:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/rr_mesh_router_fsm.sv
// Mesh node router: round-robin source pick, XY routing with YX fallback, one packet per 3 cycles.
// Optional RR_ROUTER_DROP_EN discards unroutable packets and counts them instead of sending to Node.
import router_pkg::*;

module rr_mesh_router_fsm #(
  parameter int PKT_W   = 32,
  parameter int COORD_W = 4
) (
  input  logic                 Clk_r,
  input  logic                 Rst,
  input  logic [2*COORD_W-1:0] Router_Address,
  input  logic [3:0]           Link_Config,
  input  logic [PKT_W-1:0]     Packet_From_N,
  input  logic [PKT_W-1:0]     Packet_From_S,
  input  logic [PKT_W-1:0]     Packet_From_W,
  input  logic [PKT_W-1:0]     Packet_From_E,
  input  logic [PKT_W-1:0]     Packet_From_Node,
  input  logic                 Empty_N,
  input  logic                 Empty_S,
  input  logic                 Empty_W,
  input  logic                 Empty_E,
  input  logic                 Empty_Node,
  input  logic                 Full_N,
  input  logic                 Full_S,
  input  logic                 Full_W,
  input  logic                 Full_E,
  input  logic                 Full_Node,
  output logic                 Read_N,
  output logic                 Read_S,
  output logic                 Read_W,
  output logic                 Read_E,
  output logic                 Read_Node,
  output logic [PKT_W-1:0]     Packet_Out,
  output logic                 Write_N,
  output logic                 Write_S,
  output logic                 Write_W,
  output logic                 Write_E,
  output logic                 Write_Node,
  output logic                 Busy
`ifdef RR_ROUTER_DROP_EN
  ,
  output logic                 Drop_Pulse,
  output logic [15:0]          Drop_Count
`endif
);

  state_t               state;
  port_t                rr_ptr;
  port_t                target;
  logic [NUM_PORTS-1:0] read_q;
  logic [NUM_PORTS-1:0] write_vec;
  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] grant;
  logic [NUM_PORTS-1:0] full_vec;
  port_t                grant_idx;
  port_t                next_ptr;
  logic [PKT_W-1:0]     src_pkt;

  logic [COORD_W-1:0]   rx, ry, dx, dy;
  port_t                x_port, y_port, candidate, route_target;
  logic                 unroutable;

  // Node is always eligible; link sources need their link enabled.
  assign req      = ~{Empty_Node, Empty_E, Empty_W, Empty_S, Empty_N} & {1'b1, Link_Config};
  assign full_vec = {Full_Node, Full_E, Full_W, Full_S, Full_N};
  assign next_ptr = (grant_idx == PORT_NODE) ? PORT_N : grant_idx + 3'd1;

  rr_arbiter5 u_arb (
    .req       (req),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    case (grant_idx)
      PORT_N:  src_pkt = Packet_From_N;
      PORT_S:  src_pkt = Packet_From_S;
      PORT_W:  src_pkt = Packet_From_W;
      PORT_E:  src_pkt = Packet_From_E;
      default: src_pkt = Packet_From_Node;
    endcase
  end

  assign rx = Router_Address[2*COORD_W-1 -: COORD_W];
  assign ry = Router_Address[COORD_W-1:0];
  assign dx = COORD_W'(get_dest_x(MAX_PKT_W'(Packet_Out), PKT_W, COORD_W));
  assign dy = COORD_W'(get_dest_y(MAX_PKT_W'(Packet_Out), PKT_W, COORD_W));

  // X first; a disabled X link falls back to Y only when Y still has distance to cover.
  always_comb begin
    x_port     = PORT_NODE;
    y_port     = PORT_NODE;
    candidate  = PORT_NODE;
    unroutable = 1'b0;
    if (dx > rx)      x_port = PORT_E;
    else if (dx < rx) x_port = PORT_W;
    if (dy > ry)      y_port = PORT_N;
    else if (dy < ry) y_port = PORT_S;
    if (x_port != PORT_NODE) begin
      if (Link_Config[x_port[1:0]])                               candidate = x_port;
      else if (y_port != PORT_NODE && Link_Config[y_port[1:0]])   candidate = y_port;
      else                                                        unroutable = 1'b1;
    end else if (y_port != PORT_NODE) begin
      if (Link_Config[y_port[1:0]]) candidate = y_port;
      else                          unroutable = 1'b1;
    end
    route_target = unroutable ? PORT_NODE : candidate;
  end

  always_ff @(posedge Clk_r or posedge Rst) begin
    if (Rst) begin
      state      <= SCAN;
      rr_ptr     <= PORT_N;
      target     <= PORT_NODE;
      read_q     <= '0;
      Packet_Out <= '0;
`ifdef RR_ROUTER_DROP_EN
      Drop_Pulse <= 1'b0;
      Drop_Count <= '0;
`endif
    end else begin
      read_q <= '0;
`ifdef RR_ROUTER_DROP_EN
      Drop_Pulse <= 1'b0;
`endif
      case (state)
        SCAN: if (|grant) begin
          Packet_Out <= src_pkt;
          read_q     <= grant;
          rr_ptr     <= next_ptr;
          state      <= ROUTE;
        end
        ROUTE: begin
`ifdef RR_ROUTER_DROP_EN
          if (unroutable) begin
            Drop_Pulse <= 1'b1;
            if (Drop_Count != 16'hFFFF) Drop_Count <= Drop_Count + 16'd1;
            state <= SCAN;
          end else begin
            target <= route_target;
            state  <= XMIT;
          end
`else
          target <= route_target;
          state  <= XMIT;
`endif
        end
        XMIT: if (!full_vec[target]) state <= SCAN;
        default: state <= SCAN;
      endcase
    end
  end

  // The push strobe follows Full within the cycle so a stalled packet leaves the moment space opens.
  always_comb begin
    write_vec = '0;
    if (state == XMIT && !full_vec[target]) write_vec[target] = 1'b1;
  end

  assign {Read_Node, Read_E, Read_W, Read_S, Read_N}      = read_q;
  assign {Write_Node, Write_E, Write_W, Write_S, Write_N} = write_vec;
  assign Busy = (state != SCAN);

endmodule

// File: tb/tb_rr_mesh_router_fsm.sv
// Directed self-checking bench for rr_mesh_router_fsm; follows RR_ROUTER_DROP_EN when defined.
module tb_rr_mesh_router_fsm;

  logic        Clk_r;
  logic        Rst;
  logic [7:0]  Router_Address;
  logic [3:0]  Link_Config;
  logic [31:0] tb_pkt [5];
  logic [4:0]  tb_empty;
  logic [4:0]  tb_full;
  logic        Read_N, Read_S, Read_W, Read_E, Read_Node;
  logic        Write_N, Write_S, Write_W, Write_E, Write_Node;
  logic [31:0] Packet_Out;
  logic        Busy;
`ifdef RR_ROUTER_DROP_EN
  logic        Drop_Pulse;
  logic [15:0] Drop_Count;
`endif
  logic [4:0]  rd, wr;

  int n_cmp = 0;
  int n_err = 0;

  assign rd = {Read_Node, Read_E, Read_W, Read_S, Read_N};
  assign wr = {Write_Node, Write_E, Write_W, Write_S, Write_N};

  rr_mesh_router_fsm #(.PKT_W(32), .COORD_W(4)) dut (
    .Clk_r(Clk_r), .Rst(Rst), .Router_Address(Router_Address), .Link_Config(Link_Config),
    .Packet_From_N(tb_pkt[0]), .Packet_From_S(tb_pkt[1]), .Packet_From_W(tb_pkt[2]),
    .Packet_From_E(tb_pkt[3]), .Packet_From_Node(tb_pkt[4]),
    .Empty_N(tb_empty[0]), .Empty_S(tb_empty[1]), .Empty_W(tb_empty[2]),
    .Empty_E(tb_empty[3]), .Empty_Node(tb_empty[4]),
    .Full_N(tb_full[0]), .Full_S(tb_full[1]), .Full_W(tb_full[2]),
    .Full_E(tb_full[3]), .Full_Node(tb_full[4]),
    .Read_N(Read_N), .Read_S(Read_S), .Read_W(Read_W), .Read_E(Read_E), .Read_Node(Read_Node),
    .Packet_Out(Packet_Out),
    .Write_N(Write_N), .Write_S(Write_S), .Write_W(Write_W), .Write_E(Write_E),
    .Write_Node(Write_Node),
    .Busy(Busy)
`ifdef RR_ROUTER_DROP_EN
    , .Drop_Pulse(Drop_Pulse), .Drop_Count(Drop_Count)
`endif
  );

  initial Clk_r = 1'b0;
  always #5 Clk_r = ~Clk_r;

  task automatic test_reset();
    Rst = 1'b1;
    @(negedge Clk_r);
    n_cmp++;
    if (Busy !== 1'b0 || rd !== 5'b0 || wr !== 5'b0) begin
      n_err++;
      $display("[TB] FAIL reset_strobes: busy=%b rd=%b wr=%b expected 0/0/0", Busy, rd, wr);
    end
    n_cmp++;
    if (Packet_Out !== 32'h0) begin
      n_err++;
      $display("[TB] FAIL reset_pkt: got %h expected 00000000", Packet_Out);
    end
`ifdef RR_ROUTER_DROP_EN
    n_cmp++;
    if (Drop_Pulse !== 1'b0 || Drop_Count !== 16'd0) begin
      n_err++;
      $display("[TB] FAIL reset_drop: pulse=%b count=%0d expected 0/0", Drop_Pulse, Drop_Count);
    end
`endif
    Rst = 1'b0;
    @(negedge Clk_r);
  endtask

  task automatic test_node_to_n();
    tb_pkt[4] = 32'h3400DEAD; tb_empty[4] = 1'b0;
    @(negedge Clk_r);
    n_cmp++;
    if (rd !== 5'b10000 || Busy !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL node_read: rd=%b busy=%b expected 10000/1", rd, Busy);
    end
    tb_empty[4] = 1'b1;
    @(negedge Clk_r);
    n_cmp++;
    if (wr !== 5'b00001 || Packet_Out !== 32'h3400DEAD) begin
      n_err++;
      $display("[TB] FAIL node_write_n: wr=%b pkt=%h expected 00001/3400dead", wr, Packet_Out);
    end
    @(negedge Clk_r);
    n_cmp++;
    if (wr !== 5'b0 || Busy !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL node_idle: wr=%b busy=%b expected 00000/0", wr, Busy);
    end
  endtask

  task automatic test_five_sources();
    logic [31:0] exp_pkt [5];
    logic [4:0]  exp_wr  [5];
    exp_pkt = '{32'h33000001, 32'h43000002, 32'h23000003, 32'h32000004, 32'h35000005};
    exp_wr  = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001};
    @(negedge Clk_r);
    for (int i = 0; i < 5; i++) begin
      tb_pkt[i] = exp_pkt[i];
      tb_empty[i] = 1'b0;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk_r);
      n_cmp++;
      if (rd !== (5'b1 << i) || wr !== 5'b0) begin
        n_err++;
        $display("[TB] FAIL rr_read_%0d: rd=%b wr=%b expected %b/00000", i, rd, wr, 5'b1 << i);
      end
      tb_empty[3'(i)] = 1'b1;
      @(negedge Clk_r);
      n_cmp++;
      if (wr !== exp_wr[i] || Packet_Out !== exp_pkt[i]) begin
        n_err++;
        $display("[TB] FAIL rr_write_%0d: wr=%b pkt=%h expected %b/%h", i, wr, Packet_Out,
                 exp_wr[i], exp_pkt[i]);
      end
      @(negedge Clk_r);
      n_cmp++;
      if (wr !== 5'b0 || Busy !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL rr_gap_%0d: wr=%b busy=%b expected 00000/0", i, wr, Busy);
      end
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    tb_pkt[2] = 32'h4300FEED; tb_empty[2] = 1'b0; tb_full[3] = 1'b1;
    @(negedge Clk_r);
    n_cmp++;
    if (rd !== 5'b00100) begin
      n_err++;
      $display("[TB] FAIL bp_read: rd=%b expected 00100", rd);
    end
    tb_empty[2] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk_r);
      if (wr !== 5'b0 || Busy !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("[TB] FAIL bp_stall: %0d bad stall cycles, expected 0", bad);
    end
    tb_full[3] = 1'b0;
    #1;
    n_cmp++;
    if (wr !== 5'b01000 || Packet_Out !== 32'h4300FEED) begin
      n_err++;
      $display("[TB] FAIL bp_release: wr=%b pkt=%h expected 01000/4300feed", wr, Packet_Out);
    end
    @(negedge Clk_r);
    n_cmp++;
    if (wr !== 5'b0 || Busy !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL bp_single: wr=%b busy=%b expected 00000/0", wr, Busy);
    end
  endtask

  task automatic test_fallback();
    Link_Config = 4'b0111;
    tb_pkt[1] = 32'h4400BEEF; tb_empty[1] = 1'b0;
    @(negedge Clk_r);
    tb_empty[1] = 1'b1;
    @(negedge Clk_r);
    n_cmp++;
    if (wr !== 5'b00001 || Packet_Out !== 32'h4400BEEF) begin
      n_err++;
      $display("[TB] FAIL fb_yx: wr=%b pkt=%h expected 00001/4400beef", wr, Packet_Out);
    end
    @(negedge Clk_r);
    tb_pkt[1] = 32'h4300CAFE; tb_empty[1] = 1'b0;
    @(negedge Clk_r);
    n_cmp++;
    if (rd !== 5'b00010) begin
      n_err++;
      $display("[TB] FAIL fb_read: rd=%b expected 00010", rd);
    end
    tb_empty[1] = 1'b1;
    @(negedge Clk_r);
`ifdef RR_ROUTER_DROP_EN
    n_cmp++;
    if (Drop_Pulse !== 1'b1 || Drop_Count !== 16'd1 || wr !== 5'b0 || Busy !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL fb_drop: pulse=%b count=%0d wr=%b busy=%b expected 1/1/00000/0",
               Drop_Pulse, Drop_Count, wr, Busy);
    end
    @(negedge Clk_r);
    n_cmp++;
    if (Drop_Pulse !== 1'b0 || Drop_Count !== 16'd1) begin
      n_err++;
      $display("[TB] FAIL fb_drop_end: pulse=%b count=%0d expected 0/1", Drop_Pulse, Drop_Count);
    end
`else
    n_cmp++;
    if (wr !== 5'b10000 || Packet_Out !== 32'h4300CAFE) begin
      n_err++;
      $display("[TB] FAIL fb_to_node: wr=%b pkt=%h expected 10000/4300cafe", wr, Packet_Out);
    end
    @(negedge Clk_r);
`endif
    Link_Config = 4'b1111;
  endtask

  task automatic test_local_and_disabled();
    int bad = 0;
    tb_pkt[3] = 32'h3300DEED; tb_empty[3] = 1'b0;
    @(negedge Clk_r);
    n_cmp++;
    if (rd !== 5'b01000) begin
      n_err++;
      $display("[TB] FAIL local_read: rd=%b expected 01000", rd);
    end
    tb_empty[3] = 1'b1;
    @(negedge Clk_r);
    n_cmp++;
    if (wr !== 5'b10000 || Packet_Out !== 32'h3300DEED) begin
      n_err++;
      $display("[TB] FAIL local_write: wr=%b pkt=%h expected 10000/3300deed", wr, Packet_Out);
    end
    @(negedge Clk_r);
    Link_Config = 4'b1110;
    tb_pkt[0] = 32'h33001234; tb_empty[0] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge Clk_r);
      if (rd !== 5'b0 || Busy !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("[TB] FAIL disabled_src: %0d cycles with activity, expected 0", bad);
    end
    tb_empty[0] = 1'b1;
    Link_Config = 4'b1111;
    @(negedge Clk_r);
  endtask

  task automatic test_reset_in_xmit();
    int bad = 0;
    tb_pkt[2] = 32'h4300F00D; tb_empty[2] = 1'b0; tb_full[3] = 1'b1;
    @(negedge Clk_r);
    tb_empty[2] = 1'b1;
    @(negedge Clk_r);
    n_cmp++;
    if (Busy !== 1'b1 || wr !== 5'b0) begin
      n_err++;
      $display("[TB] FAIL rx_pre: busy=%b wr=%b expected 1/00000", Busy, wr);
    end
    Rst = 1'b1;
    #1;
    n_cmp++;
    if (Busy !== 1'b0 || Packet_Out !== 32'h0 || wr !== 5'b0 || rd !== 5'b0) begin
      n_err++;
      $display("[TB] FAIL rx_async: busy=%b pkt=%h wr=%b rd=%b expected 0/0/0/0",
               Busy, Packet_Out, wr, rd);
    end
    @(negedge Clk_r);
    Rst = 1'b0;
    tb_full[3] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge Clk_r);
      if (wr !== 5'b0 || Busy !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("[TB] FAIL rx_after: %0d cycles with activity, expected 0", bad);
    end
  endtask

  initial begin
    Rst            = 1'b1;
    Router_Address = {4'd3, 4'd3};
    Link_Config    = 4'b1111;
    tb_empty       = 5'b11111;
    tb_full        = 5'b00000;
    for (int i = 0; i < 5; i++) tb_pkt[i] = 32'h0;
    test_reset();
    test_node_to_n();
    test_five_sources();
    test_backpressure();
    test_fallback();
    test_local_and_disabled();
    test_reset_in_xmit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
